// File: rtl/ts_rx_qualifier.sv
// Training-sequence receive qualifier: counts consecutive identical TS1/TS2 ordered sets,
// tracks idle and EIEOS indications. Optional macro TS_QUAL_IGNORE_NFTS_EN drops N_FTS from the compare.
module ts_rx_qualifier #(
  parameter int unsigned REQ_COUNT  = 8,
  parameter int unsigned IDLE_COUNT = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [127:0] ordered_set_i,
  input  logic         ts1_valid_i,
  input  logic         ts2_valid_i,
  input  logic         eieos_valid_i,
  input  logic         idle_valid_i,
  input  logic [2:0]   curr_data_rate_i,
  input  logic         clear_i,
  output logic         ts1_match_o,
  output logic         ts2_match_o,
  output logic [7:0]   ts_count_o,
  output logic [7:0]   link_num_o,
  output logic [7:0]   lane_num_o,
  output logic [7:0]   nfts_o,
  output logic [7:0]   rate_id_o,
  output logic [7:0]   training_ctrl_o,
  output logic         ts_type_o,
  output logic         idle_seen_o,
  output logic         eieos_seen_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_COUNTING, ST_QUALIFIED} state_e;

  localparam logic [7:0] REQ_CNT8  = REQ_COUNT[7:0];
  localparam logic [7:0] IDLE_CNT8 = IDLE_COUNT[7:0];

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] idle_q, idle_d;
  logic [7:0] link_q, link_d, lane_q, lane_d, nfts_q, nfts_d, rate_q, rate_d, tc_q, tc_d;
  logic       type_q, type_d;
  logic       eieos_q, eieos_d;
  logic       ts1m_q, ts1m_d, ts2m_q, ts2m_d;
  logic       idle_seen_q, idle_seen_d;

  logic       ts_event, ev_type, fields_eq, is_match;
  logic [7:0] sym1, sym2, sym3, sym4, sym5;

  // Symbol positions are rate independent, so the data rate and the COM/pad bytes never matter.
  logic unused_inputs;
  assign unused_inputs = ^{curr_data_rate_i, ordered_set_i[127:48], ordered_set_i[7:0]};

  assign sym1 = ordered_set_i[15:8];
  assign sym2 = ordered_set_i[23:16];
  assign sym3 = ordered_set_i[31:24];
  assign sym4 = ordered_set_i[39:32];
  assign sym5 = ordered_set_i[47:40];

  always_comb begin
    ts_event  = ts1_valid_i | ts2_valid_i;
    ev_type   = ~ts1_valid_i;
`ifdef TS_QUAL_IGNORE_NFTS_EN
    fields_eq = (sym1 == link_q) && (sym2 == lane_q) && (sym4 == rate_q) && (sym5 == tc_q);
`else
    fields_eq = (sym1 == link_q) && (sym2 == lane_q) && (sym3 == nfts_q) &&
                (sym4 == rate_q) && (sym5 == tc_q);
`endif
    is_match  = (state_q != ST_EMPTY) && (ev_type == type_q) && fields_eq;

    state_d = state_q;
    count_d = count_q;
    idle_d  = idle_q;
    link_d  = link_q;
    lane_d  = lane_q;
    nfts_d  = nfts_q;
    rate_d  = rate_q;
    tc_d    = tc_q;
    type_d  = type_q;
    eieos_d = eieos_q;

    if (clear_i) begin
      // Reference fields deliberately survive a clear; only counting restarts.
      state_d = ST_EMPTY;
      count_d = 8'd0;
      idle_d  = 8'd0;
      eieos_d = 1'b0;
    end else begin
      if (ts_event) begin
        if (is_match) begin
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end else begin
          count_d = 8'd1;
          type_d  = ev_type;
          link_d  = sym1;
          lane_d  = sym2;
          nfts_d  = sym3;
          rate_d  = sym4;
          tc_d    = sym5;
        end
`ifdef TS_QUAL_IGNORE_NFTS_EN
        nfts_d = sym3;
`endif
        state_d = (count_d >= REQ_CNT8) ? ST_QUALIFIED : ST_COUNTING;
      end
      if (eieos_valid_i) begin
        eieos_d = 1'b1;
      end
      if (ts_event || eieos_valid_i) begin
        idle_d = 8'd0;
      end else if (idle_valid_i) begin
        idle_d = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
      end
    end

    ts1m_d      = (state_d == ST_QUALIFIED) && !type_d;
    ts2m_d      = (state_d == ST_QUALIFIED) && type_d;
    idle_seen_d = (idle_d >= IDLE_CNT8);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      count_q     <= 8'd0;
      idle_q      <= 8'd0;
      link_q      <= 8'd0;
      lane_q      <= 8'd0;
      nfts_q      <= 8'd0;
      rate_q      <= 8'd0;
      tc_q        <= 8'd0;
      type_q      <= 1'b0;
      eieos_q     <= 1'b0;
      ts1m_q      <= 1'b0;
      ts2m_q      <= 1'b0;
      idle_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      link_q      <= link_d;
      lane_q      <= lane_d;
      nfts_q      <= nfts_d;
      rate_q      <= rate_d;
      tc_q        <= tc_d;
      type_q      <= type_d;
      eieos_q     <= eieos_d;
      ts1m_q      <= ts1m_d;
      ts2m_q      <= ts2m_d;
      idle_seen_q <= idle_seen_d;
    end
  end

  assign ts1_match_o     = ts1m_q;
  assign ts2_match_o     = ts2m_q;
  assign ts_count_o      = count_q;
  assign link_num_o      = link_q;
  assign lane_num_o      = lane_q;
  assign nfts_o          = nfts_q;
  assign rate_id_o       = rate_q;
  assign training_ctrl_o = tc_q;
  assign ts_type_o       = type_q;
  assign idle_seen_o     = idle_seen_q;
  assign eieos_seen_o    = eieos_q;

endmodule

// File: doc/ts_rx_qualifier.md
TS_RX_QUALIFIER -- requirements
Module: ts_rx_qualifier

Interface
REQ-001 SHALL have parameter REQ_COUNT, default 8: consecutive identical TS count needed to qualify, range 1..255.
REQ-002 SHALL have parameter IDLE_COUNT, default 8: consecutive idle indications needed to assert idle_seen_o, range 1..255.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock for the block.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ordered_set_i, input, pcie_ordered_set_t: last received ordered set; byte n at bits [8n+7:8n].
REQ-006 SHALL have ports ts1_valid_i, ts2_valid_i, eieos_valid_i and idle_valid_i, input, 1 bit each: single-cycle qualifiers from the ordered-set decoder.
REQ-007 SHALL have port curr_data_rate_i, input, rate_speed_e: current link rate.
REQ-008 SHALL have port clear_i, input, 1 bit: LTSSM state change; restarts all counting.
REQ-009 SHALL have ports ts1_match_o and ts2_match_o, output, 1 bit each: REQ_COUNT consecutive identical TS1/TS2 seen.
REQ-010 SHALL have port ts_count_o, output, 8 bits: current consecutive-match count.
REQ-011 SHALL have ports link_num_o, lane_num_o, nfts_o, rate_id_o and training_ctrl_o, output, 8 bits each: fields of the reference TS, which are symbols 1..5.
REQ-012 SHALL have port ts_type_o, output, 1 bit: 0 for TS1, 1 for TS2 (reference TS type).
REQ-013 SHALL have port idle_seen_o, output, 1 bit: IDLE_COUNT consecutive idle indications seen.
REQ-014 SHALL have port eieos_seen_o, output, 1 bit: sticky until clear_i; an EIEOS was received.

Function
REQ-015 SHALL use FSM states ST_EMPTY (no reference), ST_COUNTING (0 < count < REQ_COUNT) and ST_QUALIFIED (count >= REQ_COUNT).
REQ-016 SHALL define a TS event as ts1_valid_i or ts2_valid_i high; if both are high, TS1 SHALL win.
REQ-017 SHALL, on a TS event in ST_EMPTY, capture symbols 1..5 and the type as the reference, set count=1, and go to ST_COUNTING (or ST_QUALIFIED if REQ_COUNT=1).
REQ-018 SHALL treat a TS event as matching when its type equals ts_type_o and symbols 1..5 equal the stored fields; on a match, count increments and saturates at 255.
REQ-019 SHALL, on a non-matching TS event in any state, recapture the reference from that TS, set count=1, drop the match outputs, and go to ST_COUNTING.
REQ-020 SHALL assert ts1_match_o or ts2_match_o (per ts_type_o) only in ST_QUALIFIED; the other match output SHALL stay 0.
REQ-021 SHALL use identical symbol indices 1..5 for gen1/gen2 and gen3; curr_data_rate_i changes SHALL NOT alter the comparison.
REQ-022 SHALL ignore eieos_valid_i for TS counting (no break); it only sets eieos_seen_o.
REQ-023 SHALL increment an idle counter (saturating) on idle_valid_i and clear it on any TS event or eieos_valid_i; idle_seen_o = (idle counter >= IDLE_COUNT).
REQ-024 SHALL register all outputs, updating them in the cycle after the qualifying input (latency 1).
REQ-025 SHALL let clear_i dominate any simultaneous valid: the same-cycle TS/idle/EIEOS input is discarded, state goes to ST_EMPTY, and counters/sticky bits go to 0; the reference fields SHALL be held.
REQ-026 SHALL hold all state in cycles with no valid input.

Reset
REQ-027 SHALL, on rst_ni low, asynchronously enter ST_EMPTY and drive every output to 0: ts*_match_o, ts_count_o, field outputs, ts_type_o, idle_seen_o and eieos_seen_o.
REQ-028 SHALL, on reset assertion mid-count, discard partial counts; the first TS after release SHALL start a new reference.

Configuration
REQ-029 SHALL, with macro TS_QUAL_IGNORE_NFTS_EN defined, exclude symbol 3 (N_FTS) from the match compare; nfts_o SHALL then update to the latest TS value on every TS event.
REQ-030 SHALL, without TS_QUAL_IGNORE_NFTS_EN, include N_FTS in the compare as in REQ-018.

Verification
REQ-031 SHALL cover: 8 TS1 with link=0x01, lane=0x00 and identical fields -> ts1_match_o=1 one cycle after the 8th, ts_count_o=8.
REQ-032 SHALL cover: 5 TS1, then a TS1 with lane=0x02 -> ts_count_o=1, lane_num_o=0x02, ts1_match_o=0; 7 more identical -> match.
REQ-033 SHALL cover: qualified TS1 stream, then one TS2 -> ts1_match_o=0, ts_type_o=1, ts_count_o=1 next cycle.
REQ-034 SHALL cover: 4 TS2, EIEOS, 4 TS2 -> ts2_match_o=1, eieos_seen_o=1; clear_i together with the 9th TS2 -> count=0, ST_EMPTY.
REQ-035 SHALL cover: 300 matching TS1 -> ts_count_o saturates at 255; rst_ni low mid-stream -> all outputs 0 immediately, without waiting for a clock.
REQ-036 SHALL cover: with TS_QUAL_IGNORE_NFTS_EN, 8 TS1 with varying N_FTS -> match; without the macro -> ts_count_o stays 1.
